// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: R/E/M stage hazard inputs, long-unit writeback,
// and the forward-select / stall / statistics outputs.
interface hazard_scoreboard_if #(
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32
);
  localparam int AW = $clog2(NREG);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [AW-1:0]    ra1_r;
  logic [AW-1:0]    ra2_r;
  logic             long_r;
  logic [AW-1:0]    wa_e;
  logic             regfile_we_e;
  logic [1:0]       src_sel_e;
  logic             long_e;
  logic             flush_e;
  logic [AW-1:0]    wa_m;
  logic             regfile_we_m;
  logic [1:0]       src_sel_m;
  logic             lu_done;
  logic [AW-1:0]    lu_wa;
  logic             stat_clr;
  logic [2:0]       rd1_sel;
  logic [2:0]       rd2_sel;
  logic             stall;
  logic [OW-1:0]    outstanding;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ra1_r, ra2_r, long_r, wa_e, regfile_we_e, src_sel_e, long_e, flush_e,
    output wa_m, regfile_we_m, src_sel_m, lu_done, lu_wa, stat_clr,
    input  rd1_sel, rd2_sel, stall, outstanding, stall_cnt
  );

  modport slave (
    input  ra1_r, ra2_r, long_r, wa_e, regfile_we_e, src_sel_e, long_e, flush_e,
    input  wa_m, regfile_we_m, src_sel_m, lu_done, lu_wa, stat_clr,
    output rd1_sel, rd2_sel, stall, outstanding, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Operand forwarding, load-use / long-latency RAW / structural stall detection,
// busy bitmap for outstanding mul/div writes, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int OW = $clog2(MAX_OUT + 1);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [2:0] SEL_RF   = 3'b000;
  localparam logic [2:0] SEL_E    = 3'b001;
  localparam logic [2:0] SEL_MALU = 3'b010;
  localparam logic [2:0] SEL_MMEM = 3'b011;
  localparam logic [2:0] SEL_LU   = 3'b100;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [OW-1:0]    outstanding_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             e_live_s, e_fwd_s, e_load_s, e_long_s, m_live_s;
  logic             issue_s, lu_free_s, slot_ok_s, set_s;
  logic             raw1_s, raw2_s, struct_s, stall_s;
  logic [OW:0]      demand_s;
  logic [NREG-1:0]  set_mask_s, clr_mask_s;

  function automatic logic [OW-1:0] popcount(input logic [NREG-1:0] v);
    logic [OW-1:0] n;
    n = {OW{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      n = n + OW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [2:0] fwd_sel(
    input logic [AW-1:0] ra,
    input logic          e_ok,
    input logic [AW-1:0] wa_e,
    input logic          m_ok,
    input logic [AW-1:0] wa_m,
    input logic [1:0]    sel_m,
    input logic          lu_ok,
    input logic [AW-1:0] lu_wa
  );
    logic [2:0] s;
    s = SEL_RF;
    if (ra == {AW{1'b0}}) begin
      s = SEL_RF;
    end else if (e_ok && (ra == wa_e)) begin
      s = SEL_E;
    end else if (m_ok && (ra == wa_m)) begin
      case (sel_m)
        SRC_ALU: s = SEL_MALU;
        SRC_MEM: s = SEL_MMEM;
        default: s = SEL_RF;
      endcase
    end else if (lu_ok && (ra == lu_wa)) begin
      s = SEL_LU;
    end else begin
      s = SEL_RF;
    end
    return s;
  endfunction

  function automatic logic src_raw(
    input logic [AW-1:0]   ra,
    input logic [AW-1:0]   wa_e,
    input logic            e_block,
    input logic [NREG-1:0] busy,
    input logic            lu_done,
    input logic [AW-1:0]   lu_wa
  );
    logic r;
    if (ra == {AW{1'b0}}) begin
      r = 1'b0;
    end else begin
      r = (e_block && (ra == wa_e)) ||
          (busy[ra] && !(lu_done && (lu_wa == ra)));
    end
    return r;
  endfunction

  // Hazard decode, stall, and busy/counter next state
  always_comb begin
    e_live_s  = bus.regfile_we_e && !bus.flush_e;
    e_fwd_s   = e_live_s && !bus.long_e;
    e_load_s  = e_live_s && (bus.src_sel_e == SRC_MEM);
    e_long_s  = e_live_s && bus.long_e;
    m_live_s  = bus.regfile_we_m;
    issue_s   = e_long_s && (bus.wa_e != {AW{1'b0}});
    lu_free_s = bus.lu_done && busy_q[bus.lu_wa];

    raw1_s = src_raw(bus.ra1_r, bus.wa_e, e_load_s || e_long_s, busy_q, bus.lu_done, bus.lu_wa);
    raw2_s = src_raw(bus.ra2_r, bus.wa_e, e_load_s || e_long_s, busy_q, bus.lu_done, bus.lu_wa);

    demand_s = (OW+1)'(outstanding_q) + (OW+1)'(issue_s);
    struct_s = bus.long_r && (demand_s >= (OW+1)'(MAX_OUT)) && !lu_free_s;
    stall_s  = rst_n && (raw1_s || raw2_s || struct_s);

    // A RAW stall only bubbles the R-stage consumer; the E-stage long op still
    // issues, so its busy bit is recorded unless the unit has no free slot.
    slot_ok_s  = (outstanding_q < OW'(MAX_OUT)) || lu_free_s;
    set_s      = issue_s && slot_ok_s;
    set_mask_s = set_s       ? (NREG'(1) << bus.wa_e)  : {NREG{1'b0}};
    clr_mask_s = bus.lu_done ? (NREG'(1) << bus.lu_wa) : {NREG{1'b0}};
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~NREG'(1);

    if (bus.stat_clr) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= {NREG{1'b0}};
      outstanding_q <= {OW{1'b0}};
      stall_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= popcount(busy_d);
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.rd1_sel     = fwd_sel(bus.ra1_r, e_fwd_s, bus.wa_e, m_live_s, bus.wa_m,
                                   bus.src_sel_m, bus.lu_done, bus.lu_wa);
  assign bus.rd2_sel     = fwd_sel(bus.ra2_r, e_fwd_s, bus.wa_e, m_live_s, bus.wa_m,
                                   bus.src_sel_m, bus.lu_done, bus.lu_wa);
  assign bus.stall       = stall_s;
  assign bus.outstanding = outstanding_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule
